// File: rtl/amm2ahb_pkg.sv
// amm2ahb_pkg: AHB-Lite codes and bridge state encoding shared by the amm2ahb bridge.
// Revision 1.0
`default_nettype none

package amm2ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ADDR = 2'b01;
  localparam logic [1:0] S_DATA = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

endpackage

`default_nettype wire

// File: rtl/amm2ahb_be_decode.sv
// amm2ahb_be_decode: maps the remaining byte mask onto one AHB transfer (size, offset, leftover lanes).
// Revision 1.0
`default_nettype none

module amm2ahb_be_decode
  import amm2ahb_pkg::*;
(
  input  logic [3:0] i_mask,
  output logic [2:0] o_hsize,
  output logic [1:0] o_offset,
  output logic [3:0] o_mask_next
);

  always_comb begin
    o_hsize     = HSIZE_BYTE;
    o_offset    = 2'd0;
    o_mask_next = 4'b0000;
    case (i_mask)
      4'b1111: o_hsize = HSIZE_WORD;
      4'b0011: o_hsize = HSIZE_HALF;
      4'b1100: begin
        o_hsize  = HSIZE_HALF;
        o_offset = 2'd2;
      end
      default: begin
        // Single lanes and unaligned patterns both issue the lowest set lane as a byte.
        if (i_mask[0]) begin
          o_mask_next = {i_mask[3:1], 1'b0};
        end else if (i_mask[1]) begin
          o_offset    = 2'd1;
          o_mask_next = {i_mask[3:2], 2'b00};
        end else if (i_mask[2]) begin
          o_offset    = 2'd2;
          o_mask_next = {i_mask[3], 3'b000};
        end else if (i_mask[3]) begin
          o_offset    = 2'd3;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/amm2ahb.sv
// amm2ahb: Avalon-MM slave to AHB-Lite master bridge, one single transfer outstanding at a time.
// Revision 1.0
`default_nettype none

module amm2ahb
  import amm2ahb_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] amm_address,
  input  logic [31:0] amm_writedata,
  input  logic [3:0]  amm_byteenable,
  input  logic        amm_write,
  input  logic        amm_read,
  output logic [31:0] amm_readdata,
  output logic        amm_waitrequest,
  output logic        bus_error,
  output logic [31:0] ahb_haddr,
  output logic [2:0]  ahb_hsize,
  output logic [1:0]  ahb_htrans,
  output logic [2:0]  ahb_hburst,
  output logic        ahb_hwrite,
  output logic [31:0] ahb_hwdata,
  input  logic [31:0] ahb_hrdata,
  input  logic        ahb_hready,
  input  logic        ahb_hresp
);

  logic [1:0]  r_state;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_readdata;
  logic        r_write;
  logic        r_err;
  logic [3:0]  r_mask;

  logic [2:0]  w_hsize;
  logic [1:0]  w_offset;
  logic [3:0]  w_mask_next;
  logic [1:0]  w_unused_addr_lsb;

  assign w_unused_addr_lsb = amm_address[1:0];

  amm2ahb_be_decode u_be_decode (
    .i_mask      (r_mask),
    .o_hsize     (w_hsize),
    .o_offset    (w_offset),
    .o_mask_next (w_mask_next)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_addr     <= 30'd0;
      r_wdata    <= 32'd0;
      r_readdata <= 32'd0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_mask     <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (amm_read || amm_write) begin
            r_addr  <= amm_address[31:2];
            r_wdata <= amm_writedata;
            r_write <= amm_write;
            r_mask  <= amm_write ? amm_byteenable : 4'b1111;
            r_state <= (amm_write && (amm_byteenable == 4'b0000)) ? S_DONE : S_ADDR;
          end
        end
        S_ADDR: begin
          if (ahb_hready) begin
            r_mask  <= w_mask_next;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (ahb_hready) begin
            if (ahb_hresp) begin
              r_err   <= 1'b1;
              r_mask  <= 4'b0000;
              r_state <= S_DONE;
              if (!r_write) r_readdata <= 32'd0;
            end else begin
              if (!r_write) r_readdata <= ahb_hrdata;
              r_state <= (r_mask != 4'b0000) ? S_ADDR : S_DONE;
            end
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // All AHB outputs come from registered state, so no Avalon input reaches them combinationally.
  assign ahb_haddr       = {r_addr, w_offset};
  assign ahb_hsize       = w_hsize;
  assign ahb_htrans      = (r_state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb_hburst      = HBURST_SINGLE;
  assign ahb_hwrite      = r_write;
  assign ahb_hwdata      = r_wdata;
  assign amm_readdata    = r_readdata;
  assign amm_waitrequest = (r_state != S_DONE);
  assign bus_error       = (r_state == S_DONE) && r_err;

endmodule

`default_nettype wire

// File: tb/tb_amm2ahb.sv
// tb_amm2ahb: directed scoreboard bench for the amm2ahb bridge with a small AHB slave model.
// Revision 1.0
`default_nettype none

module tb_amm2ahb;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] amm_address;
  logic [31:0] amm_writedata;
  logic [3:0]  amm_byteenable;
  logic        amm_write;
  logic        amm_read;
  logic [31:0] amm_readdata;
  logic        amm_waitrequest;
  logic        bus_error;
  logic [31:0] ahb_haddr;
  logic [2:0]  ahb_hsize;
  logic [1:0]  ahb_htrans;
  logic [2:0]  ahb_hburst;
  logic        ahb_hwrite;
  logic [31:0] ahb_hwdata;
  logic [31:0] ahb_hrdata;
  logic        ahb_hready;
  logic        ahb_hresp;

  always #5 aclk = ~aclk;

  amm2ahb dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .amm_address     (amm_address),
    .amm_writedata   (amm_writedata),
    .amm_byteenable  (amm_byteenable),
    .amm_write       (amm_write),
    .amm_read        (amm_read),
    .amm_readdata    (amm_readdata),
    .amm_waitrequest (amm_waitrequest),
    .bus_error       (bus_error),
    .ahb_haddr       (ahb_haddr),
    .ahb_hsize       (ahb_hsize),
    .ahb_htrans      (ahb_htrans),
    .ahb_hburst      (ahb_hburst),
    .ahb_hwrite      (ahb_hwrite),
    .ahb_hwdata      (ahb_hwdata),
    .ahb_hrdata      (ahb_hrdata),
    .ahb_hready      (ahb_hready),
    .ahb_hresp       (ahb_hresp)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  xfer_t       xq[$];
  done_t       dq[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          waits    = 0;
  bit          err_mode = 1'b0;
  logic [31:0] slave_rdata = 32'd0;
  logic [31:0] last_rd = 32'd0;
  bit          dp_active = 1'b0;
  bit          pending   = 1'b0;
  bit          drv_ready = 1'b1;
  int          dp_cnt    = 0;
  xfer_t       cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one Avalon request and queue the AHB transfers and completion it should produce.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                       input bit wr, input int nwait, input bit err, input logic [31:0] rdata);
    xfer_t       x;
    done_t       d;
    int          n;
    logic [31:0] base;
    n    = 0;
    base = {addr[31:2], 2'b00};
    @(posedge aclk);
    @(negedge aclk);
    waits       = nwait;
    err_mode    = err;
    slave_rdata = rdata;
    x.wr        = wr;
    x.wdata     = wdata;
    if (!wr || be == 4'b1111) begin
      x.addr = base; x.size = 3'b010; xq.push_back(x); n = 1;
    end else if (be == 4'b0011) begin
      x.addr = base; x.size = 3'b001; xq.push_back(x); n = 1;
    end else if (be == 4'b1100) begin
      x.addr = base + 32'd2; x.size = 3'b001; xq.push_back(x); n = 1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          x.addr = base + k; x.size = 3'b000; xq.push_back(x); n++;
        end
      end
    end
    d.err   = err;
    d.rdata = wr ? last_rd : (err ? 32'd0 : rdata);
    if (!wr) last_rd = d.rdata;
    d.cyc   = (n == 0) ? 1 : (err ? 4 + nwait : 1 + n * (2 + nwait));
    dq.push_back(d);
    amm_address    = addr;
    amm_writedata  = wdata;
    amm_byteenable = be;
    amm_write      = wr;
    amm_read       = !wr;
  endtask

  task automatic run(input int limit, input bit expect_done);
    int    cyc;
    bit    done;
    xfer_t x;
    done_t d;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < limit) begin
      @(posedge aclk);
      cyc++;
      @(negedge aclk);
      if (dp_active && drv_ready) dp_active = 1'b0;
      if (pending) begin
        dp_active = 1'b1; dp_cnt = 0; pending = 1'b0;
      end
      if (dp_active) begin
        check("htrans_data_phase", {30'd0, ahb_htrans}, 32'd0);
        if (cur.wr) check("hwdata", ahb_hwdata, cur.wdata);
      end
      if (ahb_htrans == 2'b10) begin
        if (xq.size() == 0) begin
          n_assert++; n_fail++;
          $error("FAIL unexpected_nonseq observed haddr=%h expected no transfer", ahb_haddr);
        end else begin
          x = xq.pop_front();
          check("haddr", ahb_haddr, x.addr);
          check("hsize", {29'd0, ahb_hsize}, {29'd0, x.size});
          check("hwrite", {31'd0, ahb_hwrite}, {31'd0, x.wr});
          cur = x;
        end
      end
      if (!amm_waitrequest) begin
        if (dq.size() == 0) begin
          n_assert++; n_fail++;
          $error("FAIL unexpected_completion observed waitrequest=0 expected 1");
        end else begin
          d = dq.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("readdata", amm_readdata, d.rdata);
          check("bus_error", {31'd0, bus_error}, {31'd0, d.err});
          check("xfers_left", xq.size(), 32'd0);
        end
        amm_read  = 1'b0;
        amm_write = 1'b0;
        done      = 1'b1;
      end else begin
        check("bus_error_idle", {31'd0, bus_error}, 32'd0);
      end
      // Slave response for the coming edge: wait states, then optional two-cycle ERROR.
      ahb_hrdata = 32'hDEAD_BEEF;
      if (dp_active) begin
        if (dp_cnt < waits) begin
          ahb_hready = 1'b0; ahb_hresp = 1'b0;
        end else if (err_mode && dp_cnt == waits) begin
          ahb_hready = 1'b0; ahb_hresp = 1'b1;
        end else if (err_mode) begin
          ahb_hready = 1'b1; ahb_hresp = 1'b1;
        end else begin
          ahb_hready = 1'b1; ahb_hresp = 1'b0; ahb_hrdata = slave_rdata;
        end
        dp_cnt++;
      end else begin
        ahb_hready = 1'b1; ahb_hresp = 1'b0;
      end
      drv_ready = ahb_hready;
      if (ahb_htrans == 2'b10 && ahb_hready) pending = 1'b1;
    end
    if (expect_done && !done) begin
      n_assert++; n_fail++;
      $error("FAIL timeout observed no completion in %0d cycles expected completion", limit);
    end
  endtask

  initial begin
    aresetn        = 1'b0;
    amm_address    = 32'd0;
    amm_writedata  = 32'd0;
    amm_byteenable = 4'd0;
    amm_write      = 1'b0;
    amm_read       = 1'b0;
    ahb_hrdata     = 32'd0;
    ahb_hready     = 1'b1;
    ahb_hresp      = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_waitrequest", {31'd0, amm_waitrequest}, 32'd1);
    check("rst_readdata", amm_readdata, 32'd0);
    check("rst_bus_error", {31'd0, bus_error}, 32'd0);
    check("rst_htrans", {30'd0, ahb_htrans}, 32'd0);
    check("rst_haddr", ahb_haddr, 32'd0);
    check("rst_hsize", {29'd0, ahb_hsize}, 32'd0);
    check("rst_hwrite", {31'd0, ahb_hwrite}, 32'd0);
    check("rst_hwdata", ahb_hwdata, 32'd0);
    check("hburst", {29'd0, ahb_hburst}, 32'd0);
    aresetn = 1'b1;

    issue(32'h0000_1000, 32'h0, 4'b0110, 1'b0, 0, 1'b0, 32'hCAFE_F00D);
    run(20, 1'b1);
    issue(32'h0000_2000, 32'h1122_3344, 4'b1100, 1'b1, 0, 1'b0, 32'h0);
    run(20, 1'b1);
    issue(32'h0000_3000, 32'hA5A5_5A5A, 4'b0101, 1'b1, 0, 1'b0, 32'h0);
    run(20, 1'b1);
    issue(32'h0000_3800, 32'h7777_8888, 4'b0000, 1'b1, 0, 1'b0, 32'h0);
    run(20, 1'b1);
    issue(32'h0000_3C00, 32'h0102_0304, 4'b1011, 1'b1, 1, 1'b0, 32'h0);
    run(30, 1'b1);
    issue(32'h0000_4000, 32'h0, 4'b1111, 1'b0, 3, 1'b1, 32'h5555_AAAA);
    run(30, 1'b1);
    issue(32'h0000_4400, 32'hFEED_0001, 4'b0011, 1'b1, 2, 1'b0, 32'h0);
    run(30, 1'b1);

    // Split write interrupted by reset while its first data phase is in flight.
    issue(32'h0000_5000, 32'h9999_0000, 4'b0101, 1'b1, 0, 1'b0, 32'h0);
    run(2, 1'b0);
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("rst_mid_htrans", {30'd0, ahb_htrans}, 32'd0);
    check("rst_mid_waitrequest", {31'd0, amm_waitrequest}, 32'd1);
    xq.delete();
    dq.delete();
    dp_active  = 1'b0;
    pending    = 1'b0;
    drv_ready  = 1'b1;
    ahb_hready = 1'b1;
    ahb_hresp  = 1'b0;
    amm_write  = 1'b0;
    amm_read   = 1'b0;
    last_rd    = 32'd0;
    aresetn    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      check("post_rst_htrans", {30'd0, ahb_htrans}, 32'd0);
      check("post_rst_waitrequest", {31'd0, amm_waitrequest}, 32'd1);
    end
    check("post_rst_readdata", amm_readdata, 32'd0);

    issue(32'h0000_6003, 32'h0, 4'b0000, 1'b0, 1, 1'b0, 32'h1234_5678);
    run(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
